// File: rtl/comet_fetch_if.sv
// Fetch-unit bus: program-memory read port, redirect input and the
// instruction hand-off to the decoder. The master side is the fetch unit.
interface comet_fetch_if;
    logic        mem_re;
    logic [15:0] mem_raddr;
    logic [15:0] mem_rdata;
    logic        pc_load;
    logic [15:0] pc_load_addr;
    logic        ir_valid;
    logic        ir_ready;
    logic [15:0] ir_word1;
    logic [15:0] ir_word2;
    logic        ir_len2;
    logic [15:0] ir_pc;
    logic        ir_illegal;

    modport master (
        output mem_re, mem_raddr, ir_valid, ir_word1, ir_word2, ir_len2, ir_pc, ir_illegal,
        input  mem_rdata, pc_load, pc_load_addr, ir_ready
    );

    modport slave (
        input  mem_re, mem_raddr, ir_valid, ir_word1, ir_word2, ir_len2, ir_pc, ir_illegal,
        output mem_rdata, pc_load, pc_load_addr, ir_ready
    );
endinterface

// File: rtl/comet_fetch.sv
// COMET II instruction fetch: reads one or two words per instruction and holds them for the decoder.
// Optional macro COMET_FETCH_ILLEGAL_EN flags unknown opcodes and treats them as one-word.
module comet_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic mclk,
    input  logic reset,
    comet_fetch_if.master bus
);

    typedef enum logic [1:0] {FETCH1, FETCH2, HOLD} state_t;

    typedef struct packed {
        logic [15:0] word1;
        logic [15:0] word2;
        logic        len2;
        logic [15:0] pc;
        logic        illegal;
    } ir_t;

    state_t      state;
    logic [15:0] pc;
    ir_t         ir_q;
    logic        ir_valid_q;

    logic [7:0]  opcode;
    logic        one_word;
    logic        illegal;
    logic        two_word;

    assign opcode = bus.mem_rdata[15:8];

    always_comb begin
        one_word = 1'b0;
        case (opcode)
            8'h00, 8'h14, 8'h24, 8'h25, 8'h26, 8'h27,
            8'h34, 8'h35, 8'h36, 8'h44, 8'h45, 8'h71, 8'h81: one_word = 1'b1;
            default:                                         one_word = 1'b0;
        endcase
    end

`ifdef COMET_FETCH_ILLEGAL_EN
    logic legal;

    always_comb begin
        legal = 1'b0;
        case (opcode)
            8'h00, 8'h10, 8'h11, 8'h12, 8'h14,
            8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27,
            8'h30, 8'h31, 8'h32, 8'h34, 8'h35, 8'h36,
            8'h40, 8'h41, 8'h44, 8'h45,
            8'h50, 8'h51, 8'h52, 8'h53,
            8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66,
            8'h70, 8'h71, 8'h80, 8'h81, 8'hF0:     legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
    end

    assign illegal = ~legal;
`else
    assign illegal = 1'b0;
`endif

    // Illegal opcodes carry no address word, so they never enter FETCH2.
    assign two_word = ~one_word & ~illegal;

    always_ff @(posedge mclk) begin
        if (reset) begin
            state      <= FETCH1;
            pc         <= RESET_PC;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
        end else if (bus.pc_load) begin
            state      <= FETCH1;
            pc         <= bus.pc_load_addr;
            ir_valid_q <= 1'b0;
        end else begin
            case (state)
                FETCH1: begin
                    ir_q.word1   <= bus.mem_rdata;
                    ir_q.pc      <= pc;
                    ir_q.illegal <= illegal;
                    ir_q.len2    <= two_word;
                    pc           <= pc + 16'd1;
                    if (two_word) begin
                        state <= FETCH2;
                    end else begin
                        ir_q.word2 <= '0;
                        state      <= HOLD;
                        ir_valid_q <= 1'b1;
                    end
                end
                FETCH2: begin
                    ir_q.word2 <= bus.mem_rdata;
                    pc         <= pc + 16'd1;
                    state      <= HOLD;
                    ir_valid_q <= 1'b1;
                end
                HOLD: begin
                    if (bus.ir_ready) begin
                        state      <= FETCH1;
                        ir_valid_q <= 1'b0;
                    end
                end
                default: state <= FETCH1;
            endcase
        end
    end

    // HOLD is only ever entered right after a read that bumped pc, so pc-1
    // is the last address presented; this keeps mem_raddr steady while idle.
    assign bus.mem_re     = ~reset & (state != HOLD);
    assign bus.mem_raddr  = (state == HOLD) ? pc - 16'd1 : pc;

    assign bus.ir_valid   = ir_valid_q;
    assign bus.ir_word1   = ir_q.word1;
    assign bus.ir_word2   = ir_q.word2;
    assign bus.ir_len2    = ir_q.len2;
    assign bus.ir_pc      = ir_q.pc;
    assign bus.ir_illegal = ir_q.illegal;

endmodule

// File: tb/tb_comet_fetch.sv
// Self-checking bench for comet_fetch: directed scenarios plus a randomized
// run scored against an instruction-stream model of program memory.
module tb_comet_fetch;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic mclk = 1'b0;
    logic reset;
    comet_fetch_if ifc ();

    comet_fetch #(.RESET_PC(RESET_PC)) dut (
        .mclk  (mclk),
        .reset (reset),
        .bus   (ifc)
    );

    logic [15:0] mem [0:65535];
    assign ifc.mem_rdata = mem[ifc.mem_raddr];

    int checks = 0;
    int errors = 0;

    always #5 mclk = ~mclk;

    function automatic bit m_one_word(input logic [7:0] op);
        return op inside {8'h00, 8'h14, [8'h24:8'h27], [8'h34:8'h36], 8'h44, 8'h45, 8'h71, 8'h81};
    endfunction

    function automatic bit m_legal(input logic [7:0] op);
        return op inside {8'h00, [8'h10:8'h12], 8'h14, [8'h20:8'h27], [8'h30:8'h32], [8'h34:8'h36],
                          8'h40, 8'h41, 8'h44, 8'h45, [8'h50:8'h53], [8'h61:8'h66],
                          8'h70, 8'h71, 8'h80, 8'h81, 8'hF0};
    endfunction

    function automatic bit m_ill(input logic [7:0] op);
`ifdef COMET_FETCH_ILLEGAL_EN
        return !m_legal(op);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_len2(input logic [7:0] op);
        return !m_one_word(op) && !m_ill(op);
    endfunction

    // Expected {word1, word2, len2, illegal, pc} for an instruction starting at p.
    function automatic logic [65:0] m_instr(input logic [15:0] p);
        logic [15:0] p1;
        logic [7:0]  op;
        p1 = p + 16'd1;
        op = mem[p][15:8];
        return {mem[p], m_len2(op) ? mem[p1] : 16'h0000, m_len2(op), m_ill(op), p};
    endfunction

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic wait_valid(input int max, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (ifc.ir_valid !== 1'b1 && cyc < max);
    endtask

    task automatic redirect(input logic [15:0] a);
        ifc.pc_load      = 1'b1;
        ifc.pc_load_addr = a;
        step();
        ifc.pc_load      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ifc.pc_load = 1'b1;
        ifc.pc_load_addr = 16'h1234;
        ifc.ir_ready = 1'b0;
        step();
        step();
        ifc.pc_load = 1'b0;
        checks++;
        if ({ifc.ir_valid, ifc.ir_word1, ifc.ir_word2, ifc.ir_len2, ifc.ir_pc, ifc.ir_illegal} !== '0)
            $display("FAIL reset_ir: got v=%b w1=%h w2=%h l=%b pc=%h ill=%b, expected all zero",
                     ifc.ir_valid, ifc.ir_word1, ifc.ir_word2, ifc.ir_len2, ifc.ir_pc, ifc.ir_illegal);
        if ({ifc.ir_valid, ifc.ir_word1, ifc.ir_word2, ifc.ir_len2, ifc.ir_pc, ifc.ir_illegal} !== '0) errors++;
        checks++;
        if (ifc.mem_re !== 1'b0 || ifc.mem_raddr !== RESET_PC) begin
            errors++;
            $display("FAIL reset_mem: got re=%b addr=%h, expected re=0 addr=%h", ifc.mem_re, ifc.mem_raddr, RESET_PC);
        end
    endtask

    task automatic test_two_word();
        int cyc;
        mem[16'h0000] = 16'h1210;
        mem[16'h0001] = 16'h0003;
        ifc.ir_ready = 1'b1;
        reset = 1'b0;
        #1;
        checks++;
        if (ifc.mem_re !== 1'b1 || ifc.mem_raddr !== RESET_PC) begin
            errors++;
            $display("FAIL first_fetch: got re=%b addr=%h, expected re=1 addr=%h", ifc.mem_re, ifc.mem_raddr, RESET_PC);
        end
        wait_valid(8, cyc);
        checks++;
        if (ifc.ir_valid !== 1'b1 || cyc != 2 ||
            {ifc.ir_word1, ifc.ir_word2, ifc.ir_len2, ifc.ir_pc} !== {16'h1210, 16'h0003, 1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL two_word: got v=%b lat=%0d w1=%h w2=%h l=%b pc=%h, expected v=1 lat=2 1210 0003 1 0000",
                     ifc.ir_valid, cyc, ifc.ir_word1, ifc.ir_word2, ifc.ir_len2, ifc.ir_pc);
        end
        step();
        ifc.ir_ready = 1'b0;
        checks++;
        if (ifc.ir_valid !== 1'b0 || ifc.mem_re !== 1'b1 || ifc.mem_raddr !== 16'h0002) begin
            errors++;
            $display("FAIL two_word_next: got v=%b re=%b addr=%h, expected v=0 re=1 addr=0002",
                     ifc.ir_valid, ifc.mem_re, ifc.mem_raddr);
        end
    endtask

    task automatic test_one_word_stall();
        logic [65:0] snap;
        logic [15:0] addr_snap;
        mem[16'h0016] = 16'h1443;
        ifc.ir_ready = 1'b0;
        redirect(16'h0016);
        checks++;
        if (ifc.ir_valid !== 1'b0 || ifc.mem_re !== 1'b1 || ifc.mem_raddr !== 16'h0016) begin
            errors++;
            $display("FAIL load_fetch: got v=%b re=%b addr=%h, expected v=0 re=1 addr=0016",
                     ifc.ir_valid, ifc.mem_re, ifc.mem_raddr);
        end
        step();
        checks++;
        if (ifc.ir_valid !== 1'b1 ||
            {ifc.ir_word1, ifc.ir_word2, ifc.ir_len2, ifc.ir_pc} !== {16'h1443, 16'h0000, 1'b0, 16'h0016}) begin
            errors++;
            $display("FAIL one_word: got v=%b w1=%h w2=%h l=%b pc=%h, expected v=1 1443 0000 0 0016",
                     ifc.ir_valid, ifc.ir_word1, ifc.ir_word2, ifc.ir_len2, ifc.ir_pc);
        end
        snap = {ifc.ir_word1, ifc.ir_word2, ifc.ir_len2, ifc.ir_illegal, ifc.ir_pc};
        addr_snap = ifc.mem_raddr;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (ifc.ir_valid !== 1'b1 || ifc.mem_re !== 1'b0 || ifc.mem_raddr !== addr_snap ||
                {ifc.ir_word1, ifc.ir_word2, ifc.ir_len2, ifc.ir_illegal, ifc.ir_pc} !== snap) begin
                errors++;
                $display("FAIL stall_%0d: got v=%b re=%b addr=%h ir=%h, expected v=1 re=0 addr=%h ir=%h",
                         i, ifc.ir_valid, ifc.mem_re, ifc.mem_raddr,
                         {ifc.ir_word1, ifc.ir_word2, ifc.ir_len2, ifc.ir_illegal, ifc.ir_pc}, addr_snap, snap);
            end
        end
        ifc.ir_ready = 1'b1;
        step();
        ifc.ir_ready = 1'b0;
        checks++;
        if (ifc.ir_valid !== 1'b0 || ifc.mem_re !== 1'b1 || ifc.mem_raddr !== 16'h0017) begin
            errors++;
            $display("FAIL stall_release: got v=%b re=%b addr=%h, expected v=0 re=1 addr=0017",
                     ifc.ir_valid, ifc.mem_re, ifc.mem_raddr);
        end
    endtask

    task automatic test_redirect_fetch2();
        int cyc;
        mem[16'h0040] = 16'h1000;
        mem[16'h0041] = 16'h0050;
        mem[16'h003b] = 16'h8000;
        mem[16'h003c] = 16'h0030;
        ifc.ir_ready = 1'b0;
        redirect(16'h0040);
        step();
        checks++;
        if (ifc.mem_re !== 1'b1 || ifc.mem_raddr !== 16'h0041) begin
            errors++;
            $display("FAIL fetch2_addr: got re=%b addr=%h, expected re=1 addr=0041", ifc.mem_re, ifc.mem_raddr);
        end
        redirect(16'h003b);
        checks++;
        if (ifc.ir_valid !== 1'b0 || ifc.mem_raddr !== 16'h003b) begin
            errors++;
            $display("FAIL redirect_discard: got v=%b addr=%h, expected v=0 addr=003b", ifc.ir_valid, ifc.mem_raddr);
        end
        wait_valid(8, cyc);
        checks++;
        if (ifc.ir_valid !== 1'b1 || cyc != 2 ||
            {ifc.ir_word1, ifc.ir_word2, ifc.ir_len2, ifc.ir_pc} !== {16'h8000, 16'h0030, 1'b1, 16'h003b}) begin
            errors++;
            $display("FAIL redirect_instr: got v=%b lat=%0d w1=%h w2=%h l=%b pc=%h, expected v=1 lat=2 8000 0030 1 003b",
                     ifc.ir_valid, cyc, ifc.ir_word1, ifc.ir_word2, ifc.ir_len2, ifc.ir_pc);
        end
        ifc.ir_ready = 1'b1;
        step();
        ifc.ir_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int cyc;
        mem[16'hFFFF] = 16'h1200;
        mem[16'h0000] = 16'h1210;
        redirect(16'hFFFF);
        step();
        checks++;
        if (ifc.mem_re !== 1'b1 || ifc.mem_raddr !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_addr: got re=%b addr=%h, expected re=1 addr=0000", ifc.mem_re, ifc.mem_raddr);
        end
        wait_valid(4, cyc);
        checks++;
        if (ifc.ir_valid !== 1'b1 ||
            {ifc.ir_word1, ifc.ir_word2, ifc.ir_len2, ifc.ir_pc} !== {16'h1200, 16'h1210, 1'b1, 16'hFFFF}) begin
            errors++;
            $display("FAIL wrap_instr: got v=%b w1=%h w2=%h l=%b pc=%h, expected v=1 1200 1210 1 ffff",
                     ifc.ir_valid, ifc.ir_word1, ifc.ir_word2, ifc.ir_len2, ifc.ir_pc);
        end
        ifc.ir_ready = 1'b1;
        step();
        ifc.ir_ready = 1'b0;
        checks++;
        if (ifc.mem_raddr !== 16'h0001) begin
            errors++;
            $display("FAIL wrap_next: got addr=%h, expected 0001", ifc.mem_raddr);
        end
    endtask

    task automatic test_ff00();
        int cyc;
        mem[16'h0080] = 16'hFF00;
        mem[16'h0081] = 16'h1234;
        redirect(16'h0080);
        wait_valid(4, cyc);
        checks++;
`ifdef COMET_FETCH_ILLEGAL_EN
        if (ifc.ir_valid !== 1'b1 || cyc != 1 ||
            {ifc.ir_illegal, ifc.ir_len2, ifc.ir_word2} !== {1'b1, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL ff00: got v=%b lat=%0d ill=%b l=%b w2=%h, expected v=1 lat=1 ill=1 l=0 w2=0000",
                     ifc.ir_valid, cyc, ifc.ir_illegal, ifc.ir_len2, ifc.ir_word2);
        end
`else
        if (ifc.ir_valid !== 1'b1 || cyc != 2 ||
            {ifc.ir_illegal, ifc.ir_len2, ifc.ir_word2} !== {1'b0, 1'b1, 16'h1234}) begin
            errors++;
            $display("FAIL ff00: got v=%b lat=%0d ill=%b l=%b w2=%h, expected v=1 lat=2 ill=0 l=1 w2=1234",
                     ifc.ir_valid, cyc, ifc.ir_illegal, ifc.ir_len2, ifc.ir_word2);
        end
`endif
        ifc.ir_ready = 1'b1;
        step();
        ifc.ir_ready = 1'b0;
    endtask

    // Every opcode once, back to back with the decoder always ready.
    task automatic test_all_opcodes();
        logic [15:0] a;
        logic [15:0] exp_pc;
        int cyc;
        int lat;
        logic [65:0] exp;
        a = 16'h1000;
        for (int op = 0; op < 256; op++) begin
            mem[a] = {op[7:0], 8'($urandom)};
            a++;
            if (m_len2(op[7:0])) begin
                mem[a] = 16'($urandom);
                a++;
            end
        end
        ifc.ir_ready = 1'b1;
        redirect(16'h1000);
        exp_pc = 16'h1000;
        for (int i = 0; i < 256; i++) begin
            exp = m_instr(exp_pc);
            lat = (exp[17] ? 2 : 1) + (i > 0 ? 1 : 0);
            wait_valid(4, cyc);
            checks++;
            if (ifc.ir_valid !== 1'b1 || cyc != lat ||
                {ifc.ir_word1, ifc.ir_word2, ifc.ir_len2, ifc.ir_illegal, ifc.ir_pc} !== exp) begin
                errors++;
                $display("FAIL opcode_%02h: got v=%b lat=%0d ir=%h, expected lat=%0d ir=%h",
                         i, ifc.ir_valid, cyc,
                         {ifc.ir_word1, ifc.ir_word2, ifc.ir_len2, ifc.ir_illegal, ifc.ir_pc}, lat, exp);
            end
            exp_pc = exp_pc + (exp[17] ? 16'd2 : 16'd1);
        end
        step();
        ifc.ir_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] exp_pc;
        logic [15:0] ld_addr;
        logic [65:0] exp;
        bit last_load;
        int idle;
        int hs;
        idle = 0;
        hs = 0;
        exp = '0;
        for (int a = 16'h0200; a < 16'h0800; a++) mem[a] = 16'($urandom);
        ifc.ir_ready = 1'b0;
        ifc.pc_load = 1'b1;
        ifc.pc_load_addr = 16'h0200;
        exp_pc = 16'h0200;
        last_load = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            step();
            if (last_load) begin
                idle = 0;
                checks++;
                if (ifc.ir_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_load_discard c=%0d: got v=%b, expected v=0", c, ifc.ir_valid);
                end
            end
            checks++;
            if (ifc.mem_re !== !ifc.ir_valid) begin
                errors++;
                $display("FAIL rnd_mem_re c=%0d: got re=%b, expected %b", c, ifc.mem_re, !ifc.ir_valid);
            end
            if (ifc.ir_valid === 1'b1) begin
                idle = 0;
                exp = m_instr(exp_pc);
                checks++;
                if ({ifc.ir_word1, ifc.ir_word2, ifc.ir_len2, ifc.ir_illegal, ifc.ir_pc} !== exp) begin
                    errors++;
                    $display("FAIL rnd_instr c=%0d: got %h, expected %h", c,
                             {ifc.ir_word1, ifc.ir_word2, ifc.ir_len2, ifc.ir_illegal, ifc.ir_pc}, exp);
                end
            end else begin
                idle++;
                if (idle > 3) begin
                    checks++;
                    errors++;
                    $display("FAIL rnd_timeout c=%0d: got no ir_valid for %0d cycles, expected at most 3", c, idle);
                    break;
                end
            end
            ifc.pc_load = ($urandom_range(0, 15) == 0);
            ld_addr = 16'h0200 + 16'($urandom_range(0, 255));
            ifc.pc_load_addr = ld_addr;
            ifc.ir_ready = ($urandom_range(0, 3) != 0);
            if (ifc.pc_load) exp_pc = ld_addr;
            else if (ifc.ir_valid === 1'b1 && ifc.ir_ready) begin
                exp_pc = exp_pc + (exp[17] ? 16'd2 : 16'd1);
                hs++;
            end
            last_load = ifc.pc_load;
        end
        ifc.pc_load = 1'b0;
        ifc.ir_ready = 1'b0;
        checks++;
        if (hs < 200) begin
            errors++;
            $display("FAIL rnd_progress: got %0d handshakes, expected at least 200", hs);
        end
    endtask

    task automatic test_reset_midfetch();
        int cyc;
        ifc.ir_ready = 1'b0;
        redirect(16'h0040);
        step();
        reset = 1'b1;
        step();
        checks++;
        if (ifc.ir_valid !== 1'b0 || ifc.mem_re !== 1'b0 || ifc.mem_raddr !== RESET_PC || ifc.ir_word1 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid: got v=%b re=%b addr=%h w1=%h, expected v=0 re=0 addr=%h w1=0000",
                     ifc.ir_valid, ifc.mem_re, ifc.mem_raddr, ifc.ir_word1, RESET_PC);
        end
        reset = 1'b0;
        wait_valid(8, cyc);
        checks++;
        if (ifc.ir_valid !== 1'b1 || cyc != 2 ||
            {ifc.ir_word1, ifc.ir_word2, ifc.ir_pc} !== {16'h1210, mem[16'h0001], RESET_PC}) begin
            errors++;
            $display("FAIL reset_mid_refetch: got v=%b lat=%0d w1=%h w2=%h pc=%h, expected v=1 lat=2 1210 %h %h",
                     ifc.ir_valid, cyc, ifc.ir_word1, ifc.ir_word2, ifc.ir_pc, mem[16'h0001], RESET_PC);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        ifc.pc_load = 1'b0;
        ifc.pc_load_addr = 16'h0000;
        ifc.ir_ready = 1'b0;
        reset = 1'b1;
        test_reset();
        test_two_word();
        test_one_word_stall();
        test_redirect_fetch2();
        test_wrap();
        test_ff00();
        test_all_opcodes();
        test_random();
        test_reset_midfetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/comet_fetch.md
COMET_FETCH -- requirements
Module: comet_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port mclk, input, 1 bit: sole clock; all state updates on posedge mclk.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port mem_re, output, 1 bit: program-memory read enable.
REQ-005 SHALL have port mem_raddr, output, 16 bits: program-memory word address.
REQ-006 SHALL have port mem_rdata, input, 16 bits: combinational read data, valid in the same cycle as mem_re/mem_raddr.
REQ-007 SHALL have port pc_load, input, 1 bit: redirect request (jump/call/ret).
REQ-008 SHALL have port pc_load_addr, input, 16 bits: redirect target.
REQ-009 SHALL have port ir_valid, output, 1 bit: instruction held for the decoder.
REQ-010 SHALL have port ir_ready, input, 1 bit: decoder accepts the held instruction.
REQ-011 SHALL have ports ir_word1 and ir_word2, outputs, 16 bits each: opcode word and address word.
REQ-012 SHALL have port ir_len2, output, 1 bit: 1 = two-word instruction.
REQ-013 SHALL have port ir_pc, output, 16 bits: address of ir_word1.
REQ-014 SHALL have port ir_illegal, output, 1 bit: opcode outside the COMET II set.

Function
REQ-015 SHALL implement the states FETCH1, FETCH2 and HOLD.
REQ-016 SHALL assert mem_re only in FETCH1/FETCH2 with mem_raddr=pc; otherwise mem_re=0 and mem_raddr holds its value.
REQ-017 In FETCH1 SHALL capture mem_rdata into ir_word1 and pc into ir_pc, set pc=pc+1, then go to FETCH2 if two-word, else to HOLD with ir_word2=16'h0000.
REQ-018 In FETCH2 SHALL capture mem_rdata into ir_word2, set pc=pc+1, and go to HOLD.
REQ-019 One-word opcodes (bits [15:8]) SHALL be 00,14,24-27,34-36,44,45,71,81; all others are two-word.
REQ-020 ir_valid SHALL be 1 exactly in HOLD; latency from FETCH1 entry is 1 cycle for one-word and 2 cycles for two-word.
REQ-021 In HOLD with ir_ready=1 SHALL complete the handshake and go to FETCH1 on the next cycle; with ir_ready=0 all ir_* outputs SHALL hold stable.
REQ-022 ir_ready outside HOLD SHALL be ignored.
REQ-023 pc_load SHALL have priority in any state: pc=pc_load_addr, state=FETCH1, any partial or held instruction discarded, ir_valid=0 the next cycle.
REQ-024 pc_load together with ir_ready in HOLD SHALL count the held instruction as consumed, then fetch from pc_load_addr.
REQ-025 pc increment SHALL wrap modulo 2^16 (16'hFFFF+1 = 16'h0000), including between word1 and word2.

Reset
REQ-026 reset=1 at a posedge SHALL set pc=RESET_PC and state=FETCH1; reset SHALL override pc_load.
REQ-027 During and after reset the outputs SHALL be ir_valid=0, ir_word1=ir_word2=0, ir_len2=0, ir_pc=0, ir_illegal=0 and mem_raddr=RESET_PC.
REQ-028 In the reset cycle mem_re SHALL be 0.
REQ-029 Reset mid-fetch SHALL discard the partial instruction.

Configuration
REQ-030 Macro COMET_FETCH_ILLEGAL_EN defined: opcodes not in 00,10-12,14,20-27,30-32,34-36,40,41,44,45,50-53,61-66,70,71,80,81,F0 SHALL set ir_illegal=1 and be treated as one-word.
REQ-031 Macro COMET_FETCH_ILLEGAL_EN undefined: ir_illegal SHALL be tied 0, no legality logic SHALL exist, and unknown opcodes SHALL be two-word.

Verification
REQ-032 Memory[0]=1210, [1]=0003, ir_ready=1, reset released -> ir_valid=1 on the 2nd cycle after reset with word1=1210, word2=0003, len2=1, ir_pc=0000.
REQ-033 Memory[0016]=1443, pc_load 0016 -> ir_valid=1 after 1 fetch cycle with word1=1443, len2=0, word2=0000; next fetch at 0017.
REQ-034 ir_ready=0 for 3 cycles in HOLD -> ir_* stable, mem_re=0 throughout; ir_ready=1 -> FETCH1 at pc+len on the next cycle.
REQ-035 pc_load=1, pc_load_addr=003b during FETCH2 -> partial instruction discarded; next valid instruction is word1=8000, word2=0030, ir_pc=003b.
REQ-036 pc_load FFFF with memory[FFFF]=1200 -> word2 is read from address 0000; pc=0001 afterwards.
REQ-037 With COMET_FETCH_ILLEGAL_EN defined, memory word FF00 -> ir_illegal=1, len2=0; without the macro -> ir_illegal=0, len2=1.
